// File: rtl/sgpr_multiport.sv
// Multiported scalar register file with post-reset scrub, write-first read
// bypass, write-conflict detection and registered write-completion reporting.
module sgpr_multiport #(
   parameter int NUM_REGS = 512,
   parameter int ADDR_W   = 9,
   parameter int RD_PORTS = 4,
   parameter int WR_PORTS = 2,
   parameter int DWORDS   = 4,
   parameter int WFID_W   = 6
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic                             init_done,
   input  logic [RD_PORTS-1:0]              rd_en,
   input  logic [RD_PORTS*ADDR_W-1:0]       rd_addr,
   output logic [RD_PORTS*DWORDS*32-1:0]    rd_data,
   output logic [RD_PORTS-1:0]              rd_valid,
   input  logic [WR_PORTS*DWORDS-1:0]       wr_en,
   input  logic [WR_PORTS*ADDR_W-1:0]       wr_addr,
   input  logic [WR_PORTS*DWORDS*32-1:0]    wr_data,
   input  logic [WR_PORTS-1:0]              wr_instr_done,
   input  logic [WR_PORTS*WFID_W-1:0]       wr_instr_done_wfid,
   output logic [WR_PORTS-1:0]              done,
   output logic [WR_PORTS*WFID_W-1:0]       done_wfid,
   output logic [WR_PORTS*ADDR_W-1:0]       done_dest_addr,
   output logic [WR_PORTS*DWORDS-1:0]       done_dest_valid,
   output logic                             wr_conflict
);

   typedef enum logic {INIT, RUN} state_t;

   state_t                          state_q, state_d;
   logic [ADDR_W-1:0]               scrub_cnt;
   logic [31:0]                     regs [NUM_REGS];
   logic [RD_PORTS*DWORDS*32-1:0]   rd_next;
   logic                            conflict;

   function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                   input int unsigned k);
      return base + ADDR_W'(k);
   endfunction

   always_comb begin
      state_d = state_q;
      if (state_q == INIT && scrub_cnt == ADDR_W'(NUM_REGS - DWORDS))
         state_d = RUN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= INIT;
         scrub_cnt <= '0;
         init_done <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_done <= (state_d == RUN);
         if (state_q == INIT)
            scrub_cnt <= scrub_cnt + ADDR_W'(DWORDS);
      end
   end

   // Ports are applied highest index first so the lowest-index port lands last and wins.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         for (int unsigned k = 0; k < DWORDS; k++)
            regs[lane_addr(scrub_cnt, k)] <= '0;
      end else begin
         for (int unsigned i = 0; i < WR_PORTS; i++)
            for (int unsigned j = 0; j < DWORDS; j++)
               if (wr_en[(WR_PORTS-1-i)*DWORDS + j])
                  regs[lane_addr(wr_addr[(WR_PORTS-1-i)*ADDR_W +: ADDR_W], j)] <=
                     wr_data[((WR_PORTS-1-i)*DWORDS + j)*32 +: 32];
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] a;
      logic [31:0]       v;
      rd_next = '0;
      a       = '0;
      v       = '0;
      for (int unsigned p = 0; p < RD_PORTS; p++) begin
         for (int unsigned k = 0; k < DWORDS; k++) begin
            a = lane_addr(rd_addr[p*ADDR_W +: ADDR_W], k);
            v = regs[a];
            for (int unsigned i = 0; i < WR_PORTS; i++)
               for (int unsigned j = 0; j < DWORDS; j++)
                  if (wr_en[(WR_PORTS-1-i)*DWORDS + j] &&
                      lane_addr(wr_addr[(WR_PORTS-1-i)*ADDR_W +: ADDR_W], j) == a)
                     v = wr_data[((WR_PORTS-1-i)*DWORDS + j)*32 +: 32];
            rd_next[(p*DWORDS + k)*32 +: 32] = v;
         end
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int unsigned p = 0; p < WR_PORTS; p++)
         for (int unsigned q = p + 1; q < WR_PORTS; q++)
            for (int unsigned i = 0; i < DWORDS; i++)
               for (int unsigned j = 0; j < DWORDS; j++)
                  if (wr_en[p*DWORDS + i] && wr_en[q*DWORDS + j] &&
                      lane_addr(wr_addr[p*ADDR_W +: ADDR_W], i) ==
                      lane_addr(wr_addr[q*ADDR_W +: ADDR_W], j))
                     conflict = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data         <= '0;
         rd_valid        <= '0;
         done            <= '0;
         done_wfid       <= '0;
         done_dest_addr  <= '0;
         done_dest_valid <= '0;
         wr_conflict     <= 1'b0;
      end else if (state_q == RUN) begin
         rd_valid        <= rd_en;
         done            <= wr_instr_done;
         done_wfid       <= wr_instr_done_wfid;
         done_dest_addr  <= wr_addr;
         done_dest_valid <= wr_en;
         wr_conflict     <= conflict;
         for (int unsigned p = 0; p < RD_PORTS; p++)
            if (rd_en[p])
               rd_data[p*DWORDS*32 +: DWORDS*32] <= rd_next[p*DWORDS*32 +: DWORDS*32];
      end else begin
         rd_valid        <= '0;
         done            <= '0;
         done_wfid       <= '0;
         done_dest_addr  <= '0;
         done_dest_valid <= '0;
         wr_conflict     <= 1'b0;
      end
   end

endmodule

// File: doc/sgpr_multiport.md
# sgpr_multiport

Parametrised scalar register file: the next generation of the SGPR used by the compute unit. It serves a configurable number of read and write ports, each up to DWORDS dwords wide, with per-dword write enables and address wrap-around. It has a hardware scrub that zeroes the array after reset, a write-first read bypass, write-conflict detection and registered write-completion reporting toward the issue stage. It sits between the SALU/LSU/SIMD/SIMF functional units and issue.

## Interface
Parameters:
- NUM_REGS, 512: number of 32-bit scalar registers; must be a multiple of DWORDS.
- ADDR_W, 9: address width; 2^ADDR_W = NUM_REGS.
- RD_PORTS, 4: number of read ports.
- WR_PORTS, 2: number of write ports.
- DWORDS, 4: maximum dwords per access (lane count).
- WFID_W, 6: wavefront id width.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- init_done  out  1  high once the scrub has finished; stays high until the next reset.
- rd_en  in  RD_PORTS  per-port read request.
- rd_addr  in  RD_PORTS*ADDR_W  base address for each read port.
- rd_data  out  RD_PORTS*DWORDS*32  read data; lane k of port p holds reg[(addr+k) mod NUM_REGS].
- rd_valid  out  RD_PORTS  rd_data for that port is valid this cycle.
- wr_en  in  WR_PORTS*DWORDS  per-port, per-dword write enable.
- wr_addr  in  WR_PORTS*ADDR_W  base address for each write port.
- wr_data  in  WR_PORTS*DWORDS*32  write data; lane k is written to (addr+k) mod NUM_REGS.
- wr_instr_done  in  WR_PORTS  the instruction issued on this port is complete.
- wr_instr_done_wfid  in  WR_PORTS*WFID_W  wavefront id for wr_instr_done.
- done  out  WR_PORTS  wr_instr_done, registered.
- done_wfid  out  WR_PORTS*WFID_W  wr_instr_done_wfid, registered.
- done_dest_addr  out  WR_PORTS*ADDR_W  wr_addr, registered.
- done_dest_valid  out  WR_PORTS*DWORDS  wr_en mask, registered.
- wr_conflict  out  1  two ports wrote the same dword in the previous cycle.

## Operation
- Two-state FSM, INIT and RUN.
  - rst low: FSM goes to INIT and the scrub counter clears to 0.
- INIT:
  - Each cycle zero DWORDS consecutive registers starting at the scrub counter, then advance the counter by DWORDS.
  - After the cycle that writes the last group (NUM_REGS-DWORDS), go to RUN and set init_done. This takes NUM_REGS/DWORDS cycles (128 at defaults).
  - rd_en, wr_en and wr_instr_done are ignored. rd_valid, done and done_dest_valid stay 0.
- RUN, writes:
  - Each set wr_en bit writes its lane at the clock edge.
  - Addresses wrap modulo NUM_REGS.
  - No alignment requirement.
- RUN, write conflict:
  - If two or more ports target the same dword in one cycle, the lowest-index port wins.
  - wr_conflict is 1 in the following cycle and 0 otherwise.
- RUN, reads:
  - Registered; all DWORDS lanes are always returned.
  - Same-cycle write to a read dword: rd_data returns the new (winning) write data. Bypass is per lane.
  - rd_en low: rd_data holds its last value and rd_valid is 0.
- RUN, completion:
  - done and done_wfid are captured from wr_instr_done and wr_instr_done_wfid every cycle.
  - done_dest_addr and done_dest_valid are captured from wr_addr and wr_en every cycle; done_dest_valid is 0 when there is no write.
- Reset mid-operation: all outputs clear immediately, the FSM returns to INIT and the full scrub repeats. In-flight writes are dropped.

## Timing
- Reset values:
  - init_done, rd_valid, done, done_dest_valid, wr_conflict: 0.
  - rd_data, done_wfid, done_dest_addr: all 0.
- Read latency: 1 cycle. A request at edge N gives rd_data and rd_valid after edge N+1's setup, i.e. visible in cycle N+1.
- Write visibility:
  - Same cycle through the bypass.
  - From the array on any read issued in a later cycle.
- done, done_dest_* and wr_conflict: exactly 1 cycle after the causing inputs.
- Ports are fully independent: all RD_PORTS reads and WR_PORTS writes may occur in one cycle.
- init_done rises at the end of the last scrub cycle. Accesses presented in that same cycle are ignored; the first cycle with init_done=1 accepts them.

## Test plan
1. Reset release, defaults -> init_done rises exactly 128 cycles later; a port-0 read at addr 0 returns four zero lanes; all outputs are 0 during INIT.
2. Port 0 writes addr 50, wr_en 0001, lane0 f0f0_f0f0 with wr_instr_done=1, wfid 5 -> next cycle done=1, done_wfid=5, done_dest_addr=50, done_dest_valid=0001. A port-3 read at addr 50 then returns lane0 f0f0_f0f0 one cycle after rd_en.
3. Port 1 writes addr 100, wr_en 0011, lanes {dead_dead, aaaa_a0a0} (lane1, lane0) -> a read at addr 99 returns lanes 0..3 = 0, aaaa_a0a0, dead_dead, 0.
4. Port 0 writes addr 510, wr_en 1111, data 1,2,3,4 -> regs 510, 511, 0, 1 hold 1, 2, 3, 4; a read at addr 510 returns 1, 2, 3, 4.
5. Same cycle: port 0 writes A and port 1 writes B to addr 200, and port 2 reads addr 200 -> rd_data lane0 = A; wr_conflict=1 for one cycle only; a later read of addr 200 = A.
6. Write addr 300 = 1234_5678, then pull rst low mid-run -> outputs are 0 at once; after release the scrub completes and a read of addr 300 returns 0.
